rename: RTL and testbench
=========================

RENAME -- requirements
Module: rename

Interface
REQ-001 Parameter ARCH_REGS, default 32: number of architectural registers.
REQ-002 Parameter PHYS_REGS, default 64: number of physical registers; tags are 6 bits.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: decoded instruction present on the in_* inputs.
REQ-006 Port in_ready, output, 1: rename accepts the instruction this cycle.
REQ-007 Port instr_in, input, 32: decoded instruction word.
REQ-008 Port pc_in, input, 12: instruction PC.
REQ-009 Port c_sig_in, input, 7: control signals from decode.
REQ-010 Port alu_sig_in, input, 3: ALU op from decode.
REQ-011 Port imm_in, input, 32: immediate from decode.
REQ-012 Port free_valid, input, 1: retire is returning a physical register this cycle.
REQ-013 Port free_preg, input, 6: physical register being returned.
REQ-014 Port out_valid, output, 1: renamed instruction present on the outputs.
REQ-015 Port out_ready, input, 1: downstream (issue/ROB) accepts the output.
REQ-016 Ports instr_out (32), pc_out (12), c_sig_out (7), alu_sig_out (3), imm_out (32), outputs: registered copies of the inputs.
REQ-017 Ports prs1 and prs2, outputs, 6 each: physical source tags.
REQ-018 Port prd, output, 6: newly allocated destination tag.
REQ-019 Port old_prd, output, 6: previous mapping of rd, freed at commit.
REQ-020 Port rd_valid, output, 1: instruction allocated a destination.

Function
REQ-021 The block SHALL extract fields as rs1=instr_in[19:15], rs2=instr_in[24:20], rd=instr_in[11:7], opcode=instr_in[6:0].
REQ-022 needs_rd SHALL be 1 when opcode is 0110011, 0010011, 0110111 or 0000011 and rd!=0; otherwise 0 (covers store 0100011 and unknown opcodes).
REQ-023 rs1 SHALL be used by all opcodes except 0110111; rs2 SHALL be used only by 0110011 and 0100011; an unused source SHALL output tag 0.
REQ-024 A used source SHALL output RAT[rs], read before any same-cycle RAT update.
REQ-025 Architectural x0 SHALL always map to p0; RAT[0] SHALL never be written.
REQ-026 The free list SHALL be a 32-entry circular FIFO with head, tail (5-bit, wrap 31->0) and 6-bit count.
REQ-027 in_ready SHALL equal (!out_valid || out_ready) && (!needs_rd || count!=0), computed combinationally from the current inputs.
REQ-028 fire = in_valid && in_ready; on fire with needs_rd: prd=fifo[head], old_prd=RAT[rd], RAT[rd]<=prd, head++, rd_valid=1.
REQ-029 On fire without needs_rd: prd=0, old_prd=0, rd_valid=0; no RAT or free-list change.
REQ-030 On free_valid with free_preg!=0 and count<32: fifo[tail]<=free_preg, tail++.
REQ-031 Free of p0, or free when count==32, SHALL be ignored.
REQ-032 Simultaneous allocate and accepted free: count unchanged, both pointers advance.
REQ-033 A free SHALL not satisfy an allocation in the same cycle; a stall at count==0 releases one cycle after the free.
REQ-034 Latency: outputs SHALL be registered, valid one cycle after fire.
REQ-035 If out_valid && !out_ready, all outputs SHALL hold stable; out_valid SHALL clear after a handshake with no new fire.

Reset
REQ-036 On rst: RAT[i]=i for i=0..31; fifo[k]=32+k; head=0; tail=0; count=32.
REQ-037 On rst: out_valid=0, rd_valid=0, all tag and data outputs 0.
REQ-038 rst SHALL override any same-cycle fire or free; an in-flight output is discarded.

Verification
REQ-039 After reset, add x3,x1,x2 (0x002081B3) -> next cycle: prs1=1, prs2=2, prd=32, old_prd=3, rd_valid=1.
REQ-040 Follow with addi x4,x3,5 -> prs1=32 (RAW through RAT), prs2=0, prd=33, old_prd=4.
REQ-041 Issue 32 allocating instructions with no frees -> count=0, in_ready=0 on the 33rd; free p3 -> in_ready=1 the next cycle, and that instruction gets prd=3.
REQ-042 Store sw x5,0(x6), then an instruction with rd=x0 -> rd_valid=0, prd=0, count unchanged; the store shows prs2=RAT[5].
REQ-043 Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no RAT or free-list change.
REQ-044 Same-cycle allocate and free of p40 with count=10 -> count stays 10; assert rst mid-stream -> state restored per REQ-036.

Source files
------------

// File: rtl/rename.sv
`default_nettype none
// ============================================================================
// Module   : rename
// Purpose  : Register-rename stage. Maps architectural source/destination
//            registers of a decoded instruction onto physical tags using a
//            register alias table (RAT) and a circular free list of
//            physical registers. Output is a single registered stage with a
//            valid/ready handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - decode -> rename handshake
//            instr_in, pc_in, c_sig_in, alu_sig_in, imm_in - decoded fields
//            free_valid/free_preg - physical register returned by retire
//            out_valid/out_ready - rename -> issue/ROB handshake
//            instr_out..imm_out  - registered copies of the inputs
//            prs1, prs2          - physical source tags (0 when unused)
//            prd, old_prd        - new destination tag / previous mapping
//            rd_valid            - instruction allocated a destination
// Revision : 1.0 - initial release
// ============================================================================
module rename #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic        clk,
  input  logic        rst,
  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_in,
  input  logic [11:0] pc_in,
  input  logic [6:0]  c_sig_in,
  input  logic [2:0]  alu_sig_in,
  input  logic [31:0] imm_in,
  // retire side
  input  logic        free_valid,
  input  logic [$clog2(PHYS_REGS)-1:0] free_preg,
  // issue side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_out,
  output logic [11:0] pc_out,
  output logic [6:0]  c_sig_out,
  output logic [2:0]  alu_sig_out,
  output logic [31:0] imm_out,
  output logic [$clog2(PHYS_REGS)-1:0] prs1,
  output logic [$clog2(PHYS_REGS)-1:0] prs2,
  output logic [$clog2(PHYS_REGS)-1:0] prd,
  output logic [$clog2(PHYS_REGS)-1:0] old_prd,
  output logic        rd_valid
);

  localparam int TAG_W    = $clog2(PHYS_REGS);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TAG_W-1:0] rat_q [ARCH_REGS];
  logic [TAG_W-1:0] rat_d [ARCH_REGS];
  logic [TAG_W-1:0] fl_q  [FL_DEPTH];
  logic [TAG_W-1:0] fl_d  [FL_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_out_q, instr_out_d;
  logic [11:0]      pc_out_q, pc_out_d;
  logic [6:0]       c_sig_out_q, c_sig_out_d;
  logic [2:0]       alu_sig_out_q, alu_sig_out_d;
  logic [31:0]      imm_out_q, imm_out_d;
  logic [TAG_W-1:0] prs1_q, prs1_d;
  logic [TAG_W-1:0] prs2_q, prs2_d;
  logic [TAG_W-1:0] prd_q, prd_d;
  logic [TAG_W-1:0] old_prd_q, old_prd_d;
  logic             rd_valid_q, rd_valid_d;

  // --------------------------------------------------------------------------
  // Decode of the fields rename cares about
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rs1_a, rs2_a, rd_a;
  logic       needs_rd, uses_rs1, uses_rs2;
  logic       out_slot_free, fire, alloc, free_ok;

  assign opcode = instr_in[6:0];
  assign rd_a   = instr_in[11:7];
  assign rs1_a  = instr_in[19:15];
  assign rs2_a  = instr_in[24:20];

  always_comb begin
    needs_rd = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ITYPE, OP_LUI, OP_LOAD: needs_rd = (rd_a != 5'd0);
      default:                             needs_rd = 1'b0;
    endcase
  end

  assign uses_rs1 = (opcode != OP_LUI);
  assign uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_STORE);

  // The output stage can take a new instruction when it is empty or being
  // drained this cycle. A free arriving this cycle is not visible to count_q,
  // so an allocation stalled at count==0 releases only on the next cycle.
  assign out_slot_free = !out_valid_q || out_ready;
  assign in_ready      = out_slot_free && (!needs_rd || (count_q != '0));
  assign fire          = in_valid && in_ready;
  assign alloc         = fire && needs_rd;
  // p0 is the permanent home of x0 and must never re-enter the free list;
  // a free into a full list has nowhere to go and is dropped.
  assign free_ok       = free_valid && (free_preg != '0) &&
                         (count_q < CNT_W'(FL_DEPTH));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rat_d         = rat_q;
    fl_d          = fl_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + CNT_W'(free_ok) - CNT_W'(alloc);

    out_valid_d   = out_valid_q;
    instr_out_d   = instr_out_q;
    pc_out_d      = pc_out_q;
    c_sig_out_d   = c_sig_out_q;
    alu_sig_out_d = alu_sig_out_q;
    imm_out_d     = imm_out_q;
    prs1_d        = prs1_q;
    prs2_d        = prs2_q;
    prd_d         = prd_q;
    old_prd_d     = old_prd_q;
    rd_valid_d    = rd_valid_q;

    if (fire) begin
      out_valid_d   = 1'b1;
      instr_out_d   = instr_in;
      pc_out_d      = pc_in;
      c_sig_out_d   = c_sig_in;
      alu_sig_out_d = alu_sig_in;
      imm_out_d     = imm_in;
      // Sources read the RAT as it stood before this instruction's own
      // destination update, so "add x1,x1,x1" sees the old mapping of x1.
      prs1_d        = uses_rs1 ? rat_q[rs1_a] : '0;
      prs2_d        = uses_rs2 ? rat_q[rs2_a] : '0;
      if (needs_rd) begin
        prd_d       = fl_q[head_q];
        old_prd_d   = rat_q[rd_a];
        rd_valid_d  = 1'b1;
        rat_d[rd_a] = fl_q[head_q];   // rd_a != 0 is implied by needs_rd
        head_d      = head_q + PTR_W'(1);
      end else begin
        prd_d       = '0;
        old_prd_d   = '0;
        rd_valid_d  = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end

    if (free_ok) begin
      fl_d[tail_q] = free_preg;
      tail_d       = tail_q + PTR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= TAG_W'(i);
      for (int k = 0; k < FL_DEPTH; k++)  fl_q[k]  <= TAG_W'(ARCH_REGS + k);
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= CNT_W'(FL_DEPTH);
      out_valid_q   <= 1'b0;
      instr_out_q   <= '0;
      pc_out_q      <= '0;
      c_sig_out_q   <= '0;
      alu_sig_out_q <= '0;
      imm_out_q     <= '0;
      prs1_q        <= '0;
      prs2_q        <= '0;
      prd_q         <= '0;
      old_prd_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      rat_q         <= rat_d;
      fl_q          <= fl_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      c_sig_out_q   <= c_sig_out_d;
      alu_sig_out_q <= alu_sig_out_d;
      imm_out_q     <= imm_out_d;
      prs1_q        <= prs1_d;
      prs2_q        <= prs2_d;
      prd_q         <= prd_d;
      old_prd_q     <= old_prd_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign instr_out   = instr_out_q;
  assign pc_out      = pc_out_q;
  assign c_sig_out   = c_sig_out_q;
  assign alu_sig_out = alu_sig_out_q;
  assign imm_out     = imm_out_q;
  assign prs1        = prs1_q;
  assign prs2        = prs2_q;
  assign prd         = prd_q;
  assign old_prd     = old_prd_q;
  assign rd_valid    = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rename.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename
// Purpose  : Self-checking bench for rename. A behavioural model (RAT as an
//            int array, free list as a queue) predicts in_ready and every
//            output; directed sequences pin known tag values, followed by
//            randomized traffic with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr_in, imm_in;
  logic [11:0] pc_in;
  logic [6:0]  c_sig_in;
  logic [2:0]  alu_sig_in;
  logic        free_valid;
  logic [5:0]  free_preg;
  logic        out_valid, out_ready;
  logic [31:0] instr_out, imm_out;
  logic [11:0] pc_out;
  logic [6:0]  c_sig_out;
  logic [2:0]  alu_sig_out;
  logic [5:0]  prs1, prs2, prd, old_prd;
  logic        rd_valid;

  always #5 clk = ~clk;

  rename #(.ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .c_sig_in(c_sig_in),
    .alu_sig_in(alu_sig_in), .imm_in(imm_in),
    .free_valid(free_valid), .free_preg(free_preg),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out), .c_sig_out(c_sig_out),
    .alu_sig_out(alu_sig_out), .imm_out(imm_out),
    .prs1(prs1), .prs2(prs2), .prd(prd), .old_prd(old_prd),
    .rd_valid(rd_valid)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int          m_rat[32];
  int          m_fl[$];
  bit          e_valid, e_known, e_rdv;
  logic [31:0] e_instr, e_imm;
  logic [11:0] e_pc;
  logic [6:0]  e_c;
  logic [2:0]  e_alu;
  int          e_prs1, e_prs2, e_prd, e_old;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_needs_rd(input logic [31:0] ins);
    case (ins[6:0])
      7'h33, 7'h13, 7'h37, 7'h03: return ins[11:7] != 5'd0;
      default:                    return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_fl.delete();
    for (int k = 0; k < 32; k++) m_fl.push_back(32 + k);
    e_valid = 0; e_known = 1; e_rdv = 0;
    e_instr = '0; e_imm = '0; e_pc = '0; e_c = '0; e_alu = '0;
    e_prs1 = 0; e_prs2 = 0; e_prd = 0; e_old = 0;
  endtask

  task automatic compare_outputs();
    chk("out_valid", out_valid, e_valid);
    // Data/tag fields are defined after reset and while an output is held.
    if (e_valid || e_known) begin
      chk("rd_valid", rd_valid, e_rdv);
      chk("prs1", prs1, e_prs1);
      chk("prs2", prs2, e_prs2);
      chk("prd", prd, e_prd);
      chk("old_prd", old_prd, e_old);
      chk("data", {instr_out, pc_out, c_sig_out, alu_sig_out, imm_out},
          {e_instr, e_pc, e_c, e_alu, e_imm});
    end
  endtask

  // One clock of stimulus: check previous outputs, drive, check in_ready,
  // then advance the model to the state the DUT will hold after the edge.
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit ordy,
                       input bit fv, input logic [5:0] fp, input bit r);
    bit          exp_rdy, nrd, fire, fok;
    logic [11:0] pc;
    logic [6:0]  cs;
    logic [2:0]  al;
    logic [31:0] im;
    @(negedge clk);
    compare_outputs();
    pc = 12'($urandom); cs = 7'($urandom); al = 3'($urandom); im = $urandom;
    rst = r; in_valid = iv; instr_in = ins; pc_in = pc; c_sig_in = cs;
    alu_sig_in = al; imm_in = im; out_ready = ordy; free_valid = fv; free_preg = fp;
    #1;
    nrd     = m_needs_rd(ins);
    exp_rdy = (!e_valid || ordy) && (!nrd || m_fl.size() != 0);
    chk("in_ready", in_ready, exp_rdy);
    if (r) begin
      m_reset();
    end else begin
      fire = iv && exp_rdy;
      fok  = fv && (fp != 0) && (m_fl.size() < 32);
      if (fire) begin
        e_valid = 1; e_known = 0;
        e_instr = ins; e_pc = pc; e_c = cs; e_alu = al; e_imm = im;
        e_prs1 = (ins[6:0] != 7'h37) ? m_rat[ins[19:15]] : 0;
        e_prs2 = (ins[6:0] == 7'h33 || ins[6:0] == 7'h23) ? m_rat[ins[24:20]] : 0;
        if (nrd) begin
          e_prd = m_fl.pop_front();
          e_old = m_rat[ins[11:7]];
          m_rat[ins[11:7]] = e_prd;
          e_rdv = 1;
        end else begin
          e_prd = 0; e_old = 0; e_rdv = 0;
        end
      end else if (ordy) begin
        e_valid = 0; e_known = 0;
      end
      if (fok) m_fl.push_back(int'(fp));
    end
  endtask

  // Wait until just after the edge that registers the last driven cycle.
  task automatic post();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  localparam logic [31:0] ADD_X3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] ADDI_X4 = 32'h00518213; // addi x4,x3,5
  localparam logic [31:0] SW_X5   = 32'h00532023; // sw x5,0(x6)
  localparam logic [31:0] ADD_X0  = 32'h00208033; // add x0,x1,x2

  initial begin
    logic [31:0] ins;
    rst = 1; in_valid = 0; instr_in = '0; pc_in = '0; c_sig_in = '0;
    alu_sig_in = '0; imm_in = '0; out_ready = 1; free_valid = 0; free_preg = '0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_tags", {prs1, prs2, prd, old_prd}, 0);

    // Store then rd=x0: no allocation, free list untouched.
    cycle(1, SW_X5, 1, 0, 0, 0); post();
    chk("sw_prs1", prs1, 6); chk("sw_prs2", prs2, 5);
    chk("sw_prd", prd, 0);   chk("sw_rdv", rd_valid, 0);
    cycle(1, ADD_X0, 1, 0, 0, 0); post();
    chk("x0_prd", prd, 0); chk("x0_rdv", rd_valid, 0);
    cycle(1, ADD_X3, 1, 0, 0, 0); post();
    chk("add_prs1", prs1, 1); chk("add_prs2", prs2, 2);
    chk("add_prd", prd, 32);  chk("add_old", old_prd, 3);
    chk("add_rdv", rd_valid, 1);
    cycle(1, ADDI_X4, 1, 0, 0, 0); post();
    chk("addi_prs1", prs1, 32); chk("addi_prs2", prs2, 0);
    chk("addi_prd", prd, 33);   chk("addi_old", old_prd, 4);

    // Exhaust the free list, stall, release by freeing p3.
    cycle(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 32; i++) cycle(1, addi((i % 31) + 1, 0, i), 1, 0, 0, 0);
    ins = addi(7, 1, 99);
    cycle(1, ins, 1, 1, 6'd3, 0);
    chk("stall_at_empty", in_ready, 0);
    cycle(1, ins, 1, 0, 0, 0);
    chk("release_after_free", in_ready, 1);
    post();
    chk("release_prd", prd, 3);

    // Backpressure: outputs hold while out_ready is low.
    for (int i = 0; i < 3; i++) begin
      cycle(1, addi(9, 9, i), 0, 0, 0, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    post();
    chk("bp_hold_prd", prd, 3);
    cycle(0, 0, 1, 0, 0, 0);

    // Simultaneous allocate and free at count==10.
    cycle(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 22; i++) cycle(1, addi(5, 0, i), 1, 0, 0, 0);
    cycle(1, addi(6, 0, 1), 1, 1, 6'd40, 0);
    for (int i = 0; i < 10; i++) cycle(1, addi(8, 0, i), 1, 0, 0, 0);
    post();
    chk("freed40_prd", prd, 40);
    cycle(1, addi(8, 0, 7), 1, 0, 0, 0);
    chk("empty_after_10", in_ready, 0);
    // Reset mid-stream with a fire and a free pending.
    cycle(1, addi(8, 0, 7), 1, 1, 6'd5, 1);
    cycle(1, ADD_X3, 1, 0, 0, 0); post();
    chk("post_rst_prd", prd, 32); chk("post_rst_old", old_prd, 3);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 5))
        0: op = 7'h33;
        1: op = 7'h13;
        2: op = 7'h37;
        3: op = 7'h03;
        4: op = 7'h23;
        default: op = 7'($urandom);
      endcase
      ins = {$urandom} & 32'hFFFFFF80 | {25'd0, op};
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 35, 6'($urandom),
            $urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    compare_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
